// File: rtl/lsu_bus_if.sv
// Execute-stage request/response and data-memory bus signals of the load/store unit.
// master is the LSU itself; slave is the pipeline plus memory that surround it.
interface lsu_bus_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_fault;
    logic              mem_req;
    logic              mem_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic              mem_err;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
               mem_gnt, mem_rvalid, mem_rdata, mem_err,
        output req_ready, resp_valid, resp_rdata, resp_fault,
               mem_req, mem_addr, mem_we, mem_be, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
               mem_gnt, mem_rvalid, mem_rdata, mem_err,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
               mem_req, mem_addr, mem_we, mem_be, mem_wdata
    );
endinterface

// File: rtl/lsu_bus.sv
// lsu_bus: one-op-at-a-time load/store unit; LSU_MISALIGNED_EN splits misaligned accesses into two bus beats.
// Latency 3 cycles aligned, 5 split, 1 for early faults; req_ready only in IDLE, bus fields held until mem_gnt.
module lsu_bus #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic      clk,
    input  logic      rst_n,
    lsu_bus_if.master bus
);
    localparam int               CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ1  = 3'd1,
        S_WAIT1 = 3'd2,
`ifdef LSU_MISALIGNED_EN
        S_REQ2  = 3'd3,
        S_WAIT2 = 3'd4,
`endif
        S_RESP  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        off_q, off_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              fault_q, fault_d;
    logic [31:0]       rdata_q, rdata_d;
`ifdef LSU_MISALIGNED_EN
    logic [31:0]       lo_q, lo_d;
`endif

    logic [3:0]  be_base;
    logic [31:0] load_raw;
    logic [31:0] load_ext;
    logic        timeout_hit;
    logic        resp_vld;
    logic        in_req1;

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                           input logic uns);
        logic [31:0] res;
        case (size)
            2'b00:   res = {{24{raw[7] & ~uns}}, raw[7:0]};
            2'b01:   res = {{16{raw[15] & ~uns}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    always_comb begin
        case (size_q)
            2'b00:   be_base = 4'b0001;
            2'b01:   be_base = 4'b0011;
            default: be_base = 4'b1111;
        endcase
    end

`ifdef LSU_MISALIGNED_EN
    // Byte enables and store data live in a two-word span; the upper word feeds beat 2.
    logic [7:0]  be_span;
    logic [63:0] wdata_span;
    logic [31:0] load_lo;
    logic        in_req2;

    assign be_span    = {4'b0000, be_base} << off_q;
    assign wdata_span = {32'b0, wdata_q} << {off_q, 3'b000};
    assign load_lo    = (state_q == S_WAIT2) ? lo_q : bus.mem_rdata;
    assign load_raw   = 32'({bus.mem_rdata, load_lo} >> {off_q, 3'b000});
    assign in_req2    = (state_q == S_REQ2);
`else
    logic [3:0]  be_span;
    logic [31:0] wdata_span;
    logic        req_misaligned;

    assign be_span        = be_base << off_q;
    assign wdata_span     = wdata_q << {off_q, 3'b000};
    assign load_raw       = bus.mem_rdata >> {off_q, 3'b000};
    assign req_misaligned = (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                            (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
`endif

    assign load_ext    = extend(load_raw, size_q, uns_q);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        rdata_d = rdata_q;
`ifdef LSU_MISALIGNED_EN
        lo_d    = lo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    off_d   = bus.req_addr[1:0];
                    addr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
                    wdata_d = bus.req_wdata;
                    fault_d = 1'b0;
                    rdata_d = '0;
`ifdef LSU_MISALIGNED_EN
                    if (bus.req_size == 2'b11) begin
`else
                    if (bus.req_size == 2'b11 || req_misaligned) begin
`endif
                        fault_d = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_REQ1;
                    end
                end
            end
            S_REQ1: begin
                if (bus.mem_gnt) begin
                    cnt_d   = '0;
                    state_d = S_WAIT1;
                end
            end
            S_WAIT1: begin
                if (bus.mem_rvalid) begin
                    if (bus.mem_err) begin
                        fault_d = 1'b1;
                        state_d = S_RESP;
`ifdef LSU_MISALIGNED_EN
                    end else if (|be_span[7:4]) begin
                        lo_d    = bus.mem_rdata;
                        addr_d  = addr_q + ADDR_W'(4);
                        state_d = S_REQ2;
`endif
                    end else begin
                        rdata_d = we_q ? 32'b0 : load_ext;
                        state_d = S_RESP;
                    end
                end else if (timeout_hit) begin
                    fault_d = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef LSU_MISALIGNED_EN
            S_REQ2: begin
                if (bus.mem_gnt) begin
                    cnt_d   = '0;
                    state_d = S_WAIT2;
                end
            end
            S_WAIT2: begin
                if (bus.mem_rvalid) begin
                    if (bus.mem_err) begin
                        fault_d = 1'b1;
                    end else begin
                        rdata_d = we_q ? 32'b0 : load_ext;
                    end
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    fault_d = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            rdata_q <= '0;
`ifdef LSU_MISALIGNED_EN
            lo_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
`ifdef LSU_MISALIGNED_EN
            lo_q    <= lo_d;
`endif
        end
    end

    assign resp_vld       = (state_q == S_RESP);
    assign in_req1        = (state_q == S_REQ1);
    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = resp_vld;
    assign bus.resp_fault = resp_vld & fault_q;
    assign bus.resp_rdata = resp_vld ? rdata_q : 32'b0;
    assign bus.mem_addr   = addr_q;

`ifdef LSU_MISALIGNED_EN
    assign bus.mem_req   = in_req1 | in_req2;
    assign bus.mem_we    = (in_req1 | in_req2) & we_q;
    assign bus.mem_be    = in_req1 ? be_span[3:0] : (in_req2 ? be_span[7:4] : 4'b0000);
    assign bus.mem_wdata = in_req2 ? wdata_span[63:32] : wdata_span[31:0];
`else
    assign bus.mem_req   = in_req1;
    assign bus.mem_we    = in_req1 & we_q;
    assign bus.mem_be    = in_req1 ? be_span : 4'b0000;
    assign bus.mem_wdata = wdata_span;
`endif
endmodule

// File: tb/tb_lsu_bus.sv
// Bench for lsu_bus: byte-level memory model plus a responder with random stalls, latency, errors and timeouts.
`timescale 1ns/1ps
module tb_lsu_bus;
    localparam int TIMEOUT = 4;
`ifdef LSU_MISALIGNED_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lsu_bus_if #(.ADDR_W(32)) bus ();
    lsu_bus #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_vec;
    int n_err;
    logic [31:0] wmem [logic [31:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] wa);
        if (!wmem.exists(wa)) wmem[wa] = $urandom;
        return wmem[wa];
    endfunction

    function automatic logic [31:0] ext(input logic [31:0] v, input int n, input logic uns);
        logic [31:0] r;
        if (n == 1)      r = (uns || !v[7])  ? (v & 32'h0000_00FF) : (v | 32'hFFFF_FF00);
        else if (n == 2) r = (uns || !v[15]) ? (v & 32'h0000_FFFF) : (v | 32'hFFFF_0000);
        else             r = v;
        return r;
    endfunction

    // One operation: model the expected outcome, then act as the memory for up to 60 cycles.
    task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int s0, input int l0, input int s1, input int l1, input int err_beat,
                          output logic [31:0] o_rdata, output logic [3:0] o_be0, output logic [31:0] o_wd0);
        int n, nwords, exp_cyc, exp_beats, cyc, beat, granted, stall_left, gnt_cyc, req_cycles;
        int st[2], lt[2];
        bit mis, early, exp_fault, waiting, req_seen, unstable, done;
        logic [31:0] words[2], obs_addr[2];
        logic [3:0]  exp_be[2], obs_be[2];
        logic        obs_we[2];
        logic [31:0] exp_val, exp_rdata, got_rdata, tmp;
        logic        got_fault;
        logic [68:0] snap;

        st[0] = s0; st[1] = s1; lt[0] = l0; lt[1] = l1;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        mis = (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
        early = (size == 2'd3) || (mis && !MIS_EN);
        nwords = 0; exp_val = 0;
        exp_be[0] = 0; exp_be[1] = 0; words[0] = 0; words[1] = 0;
        if (!early) begin
            for (int i = 0; i < n; i++) begin
                logic [31:0] ba, wa;
                int lane;
                bit fresh;
                ba = addr + 32'(i);
                wa = ba & ~32'h3;
                lane = int'(ba[1:0]);
                fresh = (nwords == 0);
                if (!fresh) fresh = (words[nwords-1] != wa);
                if (fresh) begin
                    words[nwords] = wa;
                    nwords++;
                end
                exp_be[nwords-1][lane] = 1'b1;
                tmp = rd_word(wa);
                exp_val[8*i +: 8] = tmp[8*lane +: 8];
            end
        end

        exp_fault = early; exp_beats = 0; exp_cyc = 1;
        if (!early) begin
            int t;
            t = 1;
            for (int k = 0; k < nwords; k++) begin
                int g;
                g = t + st[k];
                exp_beats++;
                if (lt[k] > TIMEOUT) begin
                    exp_cyc = g + TIMEOUT + 1; exp_fault = 1; break;
                end
                if (err_beat == k + 1) begin
                    exp_cyc = g + lt[k] + 1; exp_fault = 1; break;
                end
                t = g + lt[k] + 1;
                exp_cyc = t;
            end
        end
        exp_rdata = (exp_fault || we) ? 32'h0 : ext(exp_val, n, uns);

        @(negedge clk);
        check("ready_before_req", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
        bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
        cyc = 0; beat = 0; granted = 0; stall_left = 0; gnt_cyc = 0; req_cycles = 0;
        waiting = 0; req_seen = 0; unstable = 0; done = 0; snap = '0;
        got_rdata = 32'hDEAD_BEEF; got_fault = 1'bx;
        o_be0 = 4'h0; o_wd0 = 32'h0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            bus.req_valid = 1'b0;
            bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_err = 1'b0;
            if (bus.mem_req) req_cycles++;
            if (bus.resp_valid) begin
                done = 1; got_rdata = bus.resp_rdata; got_fault = bus.resp_fault;
            end else if (waiting) begin
                if (cyc == gnt_cyc + lt[beat]) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata = rd_word(obs_addr[beat]);
                    bus.mem_err = (err_beat == beat + 1);
                    waiting = 0;
                    beat++;
                end
            end else if (bus.mem_req && beat < 2) begin
                if (!req_seen) begin
                    snap = {bus.mem_addr, bus.mem_be, bus.mem_we, bus.mem_wdata};
                    req_seen = 1; stall_left = st[beat];
                end else if ({bus.mem_addr, bus.mem_be, bus.mem_we, bus.mem_wdata} !== snap) begin
                    unstable = 1;
                end
                if (stall_left == 0) begin
                    bus.mem_gnt = 1'b1; gnt_cyc = cyc; waiting = 1; req_seen = 0;
                    obs_addr[beat] = bus.mem_addr; obs_be[beat] = bus.mem_be; obs_we[beat] = bus.mem_we;
                    if (beat == 0) begin
                        o_be0 = bus.mem_be; o_wd0 = bus.mem_wdata;
                    end
                    granted++;
                    if (bus.mem_we) begin
                        logic [31:0] w;
                        w = rd_word(bus.mem_addr);
                        for (int j = 0; j < 4; j++)
                            if (bus.mem_be[j]) w[8*j +: 8] = bus.mem_wdata[8*j +: 8];
                        wmem[bus.mem_addr] = w;
                    end
                end else begin
                    stall_left--;
                end
            end
        end

        check("resp_cycle", 32'(cyc), 32'(exp_cyc));
        check("resp_fault", 32'(got_fault), 32'(exp_fault));
        check("resp_rdata", got_rdata, exp_rdata);
        check("beats", 32'(granted), 32'(exp_beats));
        check("bus_stable", 32'(unstable), 32'd0);
        if (early) check("early_no_req", 32'(req_cycles), 32'd0);
        for (int k = 0; k < exp_beats && k < granted; k++) begin
            check("beat_addr", obs_addr[k], words[k]);
            check("beat_be", 32'(obs_be[k]), 32'(exp_be[k]));
            check("beat_we", 32'(obs_we[k]), 32'(we));
        end
        if (we && !exp_fault) begin
            for (int i = 0; i < n; i++) begin
                logic [31:0] ba;
                ba = addr + 32'(i);
                tmp = rd_word(ba & ~32'h3);
                check("store_byte", 32'(tmp[8*int'(ba[1:0]) +: 8]), 32'(wdata[8*i +: 8]));
            end
        end
        o_rdata = got_rdata;
    endtask

    initial begin
        logic [31:0] r, wd;
        logic [3:0]  be;
        n_vec = 0; n_err = 0;
        rst_n = 1'b0;
        bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_unsigned = 0;
        bus.req_addr = 0; bus.req_wdata = 0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0; bus.mem_err = 0;
        #12;
        check("reset_ready", 32'(bus.req_ready), 32'd1);
        check("reset_outs", {25'b0, bus.mem_req, bus.resp_valid, bus.resp_fault, bus.mem_we, bus.mem_be}, 32'd0);
        check("reset_rdata", bus.resp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        wmem[32'h1000] = 32'h80FF_0000;
        run_op(1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0, 0, 1, 0, 1, 0, r, be, wd);
        check("lb_value", r, 32'hFFFF_FF80);
        check("lb_be", 32'(be), 32'h8);

        run_op(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'hABCD_1234, 0, 1, 0, 1, 0, r, be, wd);
        check("sh_be", 32'(be), 32'hC);
        check("sh_wdata", wd, 32'h1234_0000);

        wmem[32'h3000] = 32'hAA00_0000;
        wmem[32'h3004] = 32'h00CC_BBDD;
        run_op(1'b0, 2'd2, 1'b0, 32'h0000_3003, 32'h0, 0, 1, 0, 1, 0, r, be, wd);
        check("lw_split", r, MIS_EN ? 32'hCCBB_DDAA : 32'h0);

        run_op(1'b0, 2'd1, 1'b0, 32'h0000_4001, 32'h0, 0, 1, 0, 1, 0, r, be, wd);
        run_op(1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'h0, 4, 1, 0, 1, 1, r, be, wd);
        run_op(1'b0, 2'd2, 1'b0, 32'h0000_5004, 32'h0, 0, 99, 0, 1, 0, r, be, wd);
        run_op(1'b0, 2'd2, 1'b1, 32'h0000_5008, 32'h0, 0, TIMEOUT, 0, 1, 0, r, be, wd);
        run_op(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h1122_3344, 1, 2, 2, 1, 0, r, be, wd);
        run_op(1'b0, 2'd3, 1'b0, 32'h0000_6000, 32'h0, 0, 1, 0, 1, 0, r, be, wd);

        // Reset while waiting for the response, then a stray rvalid in IDLE.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_addr = 32'h7000;
        @(negedge clk);
        bus.req_valid = 1'b0; bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        check("wait1_not_ready", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_wait_ready", 32'(bus.req_ready), 32'd1);
        check("rst_wait_mem_req", 32'(bus.mem_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        check("stray_rvalid_resp", 32'(bus.resp_valid), 32'd0);
        check("stray_rvalid_ready", 32'(bus.req_ready), 32'd1);

        // Reset while the request is on the bus.
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_addr = 32'h7100;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("req1_mem_req", 32'(bus.mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_req_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_req_be_we", {27'b0, bus.mem_we, bus.mem_be}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 300; k++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            int l0, l1, e;
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            l0 = ($urandom_range(0, 15) == 0) ? 9 : int'($urandom_range(1, TIMEOUT));
            l1 = ($urandom_range(0, 15) == 0) ? 9 : int'($urandom_range(1, TIMEOUT));
            e  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 2)) : 0;
            run_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                   int'($urandom_range(0, 3)), l0, int'($urandom_range(0, 3)), l1, e, r, be, wd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
